// File: rtl/guess_judge_if.sv
// rtl/guess_judge_if.sv - secret/guess inputs and score outputs of the guess judge
interface guess_judge_if;
    logic       load;
    logic [3:0] s3, s2, s1, s0;
    logic       guess_valid;
    logic [3:0] g3, g2, g1, g0;
    logic       ready;
    logic       result_valid;
    logic [2:0] bulls;
    logic [2:0] cows;
    logic [3:0] tries;
    logic       win;
    logic       lose;

    modport master (
        output load, s3, s2, s1, s0, guess_valid, g3, g2, g1, g0,
        input  ready, result_valid, bulls, cows, tries, win, lose
    );

    modport slave (
        input  load, s3, s2, s1, s0, guess_valid, g3, g2, g1, g0,
        output ready, result_valid, bulls, cows, tries, win, lose
    );
endinterface

// File: rtl/guess_judge.sv
// rtl/guess_judge.sv - bulls/cows scorer: latches a secret, scores guesses one digit per cycle
module guess_judge #(
    parameter int MAX_TRIES = 10
) (
    input logic          clk,
    input logic          rst,
    guess_judge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT, BULL, COW, RESULT, OVER} state_t;

    state_t          state, state_n;
    logic [1:0]      k, k_n;
    logic [3:0][3:0] sec, sec_n;
    logic [3:0][3:0] gd, gd_n;
    logic [3:0]      used_s, used_s_n;
    logic [3:0]      used_g, used_g_n;
    logic [2:0]      wb, wb_n;
    logic [2:0]      wc, wc_n;
    logic            ready_q, ready_n;
    logic            rv_q, rv_n;
    logic [2:0]      bulls_q, bulls_n;
    logic [2:0]      cows_q, cows_n;
    logic [3:0]      tries_q, tries_n;
    logic            win_q, win_n;
    logic            lose_q, lose_n;
    logic            hit;
    logic [1:0]      jsel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            sec     <= '0;
            gd      <= '0;
            used_s  <= '0;
            used_g  <= '0;
            wb      <= '0;
            wc      <= '0;
            ready_q <= 1'b0;
            rv_q    <= 1'b0;
            bulls_q <= '0;
            cows_q  <= '0;
            tries_q <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            k       <= k_n;
            sec     <= sec_n;
            gd      <= gd_n;
            used_s  <= used_s_n;
            used_g  <= used_g_n;
            wb      <= wb_n;
            wc      <= wc_n;
            ready_q <= ready_n;
            rv_q    <= rv_n;
            bulls_q <= bulls_n;
            cows_q  <= cows_n;
            tries_q <= tries_n;
            win_q   <= win_n;
            lose_q  <= lose_n;
        end
    end

    // Lowest unused secret position holding the current guess digit.
    always_comb begin
        hit  = 1'b0;
        jsel = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (!used_s[j] && sec[j] == gd[k]) begin
                hit  = 1'b1;
                jsel = 2'(j);
            end
        end
    end

    always_comb begin
        state_n  = state;
        k_n      = k;
        sec_n    = sec;
        gd_n     = gd;
        used_s_n = used_s;
        used_g_n = used_g;
        wb_n     = wb;
        wc_n     = wc;
        rv_n     = 1'b0;
        bulls_n  = bulls_q;
        cows_n   = cows_q;
        tries_n  = tries_q;
        win_n    = win_q;
        lose_n   = lose_q;

        case (state)
            WAIT: begin
                if (bus.guess_valid && ready_q) begin
                    gd_n     = {bus.g3, bus.g2, bus.g1, bus.g0};
                    used_s_n = '0;
                    used_g_n = '0;
                    wb_n     = '0;
                    wc_n     = '0;
                    k_n      = 2'd0;
                    state_n  = BULL;
                end
            end
            BULL: begin
                if (gd[k] == sec[k]) begin
                    wb_n        = wb + 3'd1;
                    used_s_n[k] = 1'b1;
                    used_g_n[k] = 1'b1;
                end
                k_n = k + 2'd1;
                if (k == 2'd3) state_n = COW;
            end
            COW: begin
                if (!used_g[k] && hit) begin
                    wc_n           = wc + 3'd1;
                    used_s_n[jsel] = 1'b1;
                end
                k_n = k + 2'd1;
                if (k == 2'd3) state_n = RESULT;
            end
            RESULT: begin
                rv_n    = 1'b1;
                tries_n = tries_q + 4'd1;
                bulls_n = wb;
                cows_n  = wc;
                if (wb == 3'd4) begin
                    win_n   = 1'b1;
                    state_n = OVER;
                end else if (tries_q + 4'd1 == 4'(MAX_TRIES)) begin
                    lose_n  = 1'b1;
                    state_n = OVER;
                end else begin
                    state_n = WAIT;
                end
            end
            default: ;
        endcase

        // A load overrides everything, including a guess offered in the same cycle.
        if (bus.load) begin
            sec_n   = {bus.s3, bus.s2, bus.s1, bus.s0};
            tries_n = '0;
            bulls_n = '0;
            cows_n  = '0;
            win_n   = 1'b0;
            lose_n  = 1'b0;
            rv_n    = 1'b0;
            state_n = WAIT;
        end

        ready_n = (state_n == WAIT);
    end

    assign bus.ready        = ready_q;
    assign bus.result_valid = rv_q;
    assign bus.bulls        = bulls_q;
    assign bus.cows         = cows_q;
    assign bus.tries        = tries_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
endmodule

// File: tb/tb_guess_judge.sv
// tb/tb_guess_judge.sv - directed and random checks of guess_judge against a digit-count model
module tb_guess_judge;
    localparam int MAXT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    guess_judge_if bus ();
    guess_judge #(.MAX_TRIES(MAXT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;
    int exp_tries;
    bit exp_win, exp_lose;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bulls by position; cows as total digit-value overlap minus bulls.
    function automatic void score(input logic [15:0] s, input logic [15:0] g,
                                  output int b, output int c);
        int cs[16];
        int cg[16];
        int tot;
        b = 0; tot = 0;
        for (int v = 0; v < 16; v++) begin cs[v] = 0; cg[v] = 0; end
        for (int p = 0; p < 4; p++) begin
            if (s[p*4 +: 4] == g[p*4 +: 4]) b++;
            cs[s[p*4 +: 4]]++;
            cg[g[p*4 +: 4]]++;
        end
        for (int v = 0; v < 16; v++) tot += (cs[v] < cg[v]) ? cs[v] : cg[v];
        c = tot - b;
    endfunction

    function automatic logic [15:0] rnd_word(input int maxd);
        logic [15:0] w;
        for (int p = 0; p < 4; p++) w[p*4 +: 4] = 4'($urandom_range(0, maxd));
        return w;
    endfunction

    logic [15:0] cur_secret;

    task automatic drive_guess(input logic [15:0] g);
        {bus.g3, bus.g2, bus.g1, bus.g0} = g;
    endtask

    task automatic do_load(input logic [15:0] s);
        @(negedge clk);
        {bus.s3, bus.s2, bus.s1, bus.s0} = s;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        {bus.s3, bus.s2, bus.s1, bus.s0} = rnd_word(15);
        cur_secret = s;
        exp_tries = 0; exp_win = 0; exp_lose = 0;
        chk("load_ready", bus.ready, 1);
        chk("load_tries", bus.tries, 0);
        chk("load_win", bus.win, 0);
    endtask

    task automatic do_guess(input logic [15:0] g);
        int w, cyc, b, c;
        bit found;
        w = 0;
        while (bus.ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("ready_wait", bus.ready, 1);
        drive_guess(g);
        bus.guess_valid = 1'b1;
        @(negedge clk);
        bus.guess_valid = 1'b0;
        drive_guess(rnd_word(15));
        chk("ready_busy", bus.ready, 0);
        cyc = 0; found = 0;
        while (cyc < 15 && !found) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus.result_valid === 1'b1) found = 1;
        end
        chk("latency", cyc, 9);
        score(cur_secret, g, b, c);
        exp_tries++;
        exp_win  = (b == 4);
        exp_lose = !exp_win && (exp_tries == MAXT);
        chk("bulls", bus.bulls, b);
        chk("cows", bus.cows, c);
        chk("tries", bus.tries, exp_tries);
        chk("win", bus.win, exp_win);
        chk("lose", bus.lose, exp_lose);
        chk("ready_after", bus.ready, !(exp_win || exp_lose));
        @(negedge clk);
        chk("rv_pulse", bus.result_valid, 0);
    endtask

    task automatic count_rv(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) n++;
        end
    endtask

    initial begin
        int n;
        bus.load = 0; bus.guess_valid = 0;
        {bus.s3, bus.s2, bus.s1, bus.s0} = '0;
        drive_guess('0);
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.ready, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_bulls", bus.bulls, 0);
        chk("rst_cows", bus.cows, 0);
        chk("rst_tries", bus.tries, 0);
        chk("rst_win", bus.win, 0);
        chk("rst_lose", bus.lose, 0);
        rst = 0;

        do_load(16'h1234); do_guess(16'h1234);
        do_load(16'h1234); do_guess(16'h4321); do_guess(16'h1243);
        do_load(16'h1123); do_guess(16'h1111); do_guess(16'h3311);

        do_load(16'h5678);
        for (int i = 0; i < MAXT; i++) do_guess(16'h0000);
        drive_guess(16'h5678);
        bus.guess_valid = 1;
        count_rv(15, n);
        bus.guess_valid = 0;
        chk("over_no_rv", n, 0);
        chk("over_tries", bus.tries, MAXT);

        // Abort mid-COW with a fresh secret.
        do_load(16'h1234);
        drive_guess(16'h4321);
        bus.guess_valid = 1;
        @(posedge clk);
        @(negedge clk); bus.guess_valid = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        {bus.s3, bus.s2, bus.s1, bus.s0} = 16'h9999;
        bus.load = 1;
        @(negedge clk);
        bus.load = 0;
        chk("abort_ready", bus.ready, 1);
        chk("abort_tries", bus.tries, 0);
        count_rv(14, n);
        chk("abort_no_rv", n, 0);
        cur_secret = 16'h9999; exp_tries = 0; exp_win = 0; exp_lose = 0;
        do_guess(16'h9999);

        // load + guess_valid together: guess dropped.
        do_load(16'h1234);
        do_guess(16'h5555);
        @(negedge clk);
        {bus.s3, bus.s2, bus.s1, bus.s0} = 16'h1234;
        drive_guess(16'h1234);
        bus.load = 1; bus.guess_valid = 1;
        @(negedge clk);
        bus.load = 0; bus.guess_valid = 0;
        exp_tries = 0;
        count_rv(14, n);
        chk("drop_no_rv", n, 0);
        chk("drop_tries", bus.tries, 0);
        chk("drop_ready", bus.ready, 1);
        do_guess(16'h1200);

        // Async reset in the middle of BULL.
        drive_guess(16'h1234);
        bus.guess_valid = 1;
        @(posedge clk);
        @(negedge clk); bus.guess_valid = 0;
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_ready", bus.ready, 0);
        chk("arst_tries", bus.tries, 0);
        chk("arst_bulls", bus.bulls, 0);
        chk("arst_cows", bus.cows, 0);
        chk("arst_win", bus.win, 0);
        chk("arst_rv", bus.result_valid, 0);
        @(negedge clk); rst = 0;
        bus.guess_valid = 1;
        count_rv(14, n);
        bus.guess_valid = 0;
        chk("idle_no_rv", n, 0);
        chk("idle_ready", bus.ready, 0);

        for (int r = 0; r < 8; r++) begin
            do_load(rnd_word((r % 2 == 0) ? 3 : 15));
            for (int i = 0; i < 5; i++)
                if (!(exp_win || exp_lose)) do_guess(rnd_word((r % 2 == 0) ? 3 : 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
